// File: rtl/uart_frame_ctrl_p.sv
// UART frame controller: parses preamble/SOF/CMD/LEN frames, buffers write payloads,
// and returns read payloads paced by tx_ready. Optional checksum byte: FRAME_CHKSUM_EN.
module uart_frame_ctrl_p #(
  parameter int         ADDR_W  = 8,
  parameter int         PRE_CNT = 7,
  parameter logic [7:0] SOF1    = 8'hD5,
  parameter logic [7:0] SOF2    = 8'hFA,
  parameter logic [7:0] CMD_WR  = 8'hAA,
  parameter logic [7:0] CMD_RD  = 8'h55,
  parameter int         RX_TO   = 520800
)(
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_flag,
  output logic       busy,
  output logic       wr_done,
  output logic       rd_done,
  output logic       err_flag
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam int         TO_LAST  = (RX_TO > 0) ? RX_TO - 1 : 0;
  localparam logic [7:0] PRE_BYTE = 8'h55;

`ifdef FRAME_CHKSUM_EN
  typedef enum logic [3:0] {S_IDLE, S_SOF, S_CMD, S_LEN_H, S_LEN_L, S_WR_DATA,
                            S_RD_FETCH, S_RD_WAIT, S_RD_ACK, S_WR_CHK, S_RD_CHK} state_t;
`else
  typedef enum logic [3:0] {S_IDLE, S_SOF, S_CMD, S_LEN_H, S_LEN_L, S_WR_DATA,
                            S_RD_FETCH, S_RD_WAIT, S_RD_ACK} state_t;
`endif

  state_t      r_state, w_next;
  logic [3:0]  r_pre;
  logic        r_wr;
  logic [7:0]  r_len_h;
  logic [15:0] r_last, r_idx;
  logic [19:0] r_to;
  logic [7:0]  r_mem [DEPTH];
  logic [7:0]  r_tx_data;
  logic        r_tx_flag, r_wr_done, r_rd_done, r_err;
`ifdef FRAME_CHKSUM_EN
  logic [7:0]  r_sum;
  logic        r_chk_phase;
`endif

  logic [15:0] w_len;
  logic        w_len_ok, w_to_run, w_to_hit;
  logic        w_err, w_wr_done, w_rd_done, w_tx_flag, w_we, w_fetch, w_ptr_clr, w_ptr_inc;

  assign w_len    = {r_len_h, rx_data};
  assign w_len_ok = (w_len != 16'd0) && ({16'd0, w_len} <= DEPTH[31:0]);
`ifdef FRAME_CHKSUM_EN
  assign w_to_run = r_state inside {S_SOF, S_CMD, S_LEN_H, S_LEN_L, S_WR_DATA, S_WR_CHK};
`else
  assign w_to_run = r_state inside {S_SOF, S_CMD, S_LEN_H, S_LEN_L, S_WR_DATA};
`endif
  // A byte arriving on the expiry cycle wins over the timeout
  assign w_to_hit = (RX_TO != 0) && w_to_run && !rx_flag && (r_to == TO_LAST[19:0]);

  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next    = r_state;
    w_err     = 1'b0;
    w_wr_done = 1'b0;
    w_rd_done = 1'b0;
    w_tx_flag = 1'b0;
    w_we      = 1'b0;
    w_fetch   = 1'b0;
    w_ptr_clr = 1'b0;
    w_ptr_inc = 1'b0;
    case (r_state)
      S_IDLE:
        if (rx_flag && r_pre == PRE_CNT[3:0] && rx_data == SOF1) begin
          w_next    = S_SOF;
          w_ptr_clr = 1'b1;
        end
      S_SOF:
        if (rx_flag) begin
          if (rx_data == SOF2) w_next = S_CMD;
          else                 w_err  = 1'b1;
        end
      S_CMD:
        if (rx_flag) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) w_next = S_LEN_H;
          else                                        w_err  = 1'b1;
        end
      S_LEN_H:
        if (rx_flag) w_next = S_LEN_L;
      S_LEN_L:
        if (rx_flag) begin
          if (!w_len_ok) w_err  = 1'b1;
          else if (r_wr) w_next = S_WR_DATA;
          else           w_next = S_RD_FETCH;
        end
      S_WR_DATA:
        if (rx_flag) begin
          w_we      = 1'b1;
          w_ptr_inc = 1'b1;
          if (r_idx == r_last) begin
`ifdef FRAME_CHKSUM_EN
            w_next = S_WR_CHK;
`else
            w_wr_done = 1'b1;
`endif
          end
        end
`ifdef FRAME_CHKSUM_EN
      S_WR_CHK:
        if (rx_flag) begin
          if (rx_data == r_sum) w_wr_done = 1'b1;
          else                  w_err     = 1'b1;
        end
      S_RD_CHK:
        w_next = S_RD_WAIT;
`endif
      S_RD_FETCH: begin
        w_fetch = 1'b1;
        w_next  = S_RD_WAIT;
      end
      S_RD_WAIT:
        if (tx_ready) begin
          w_tx_flag = 1'b1;
          w_next    = S_RD_ACK;
        end
      // Advance only after tx_ready drops, so each ready window gets one byte
      S_RD_ACK:
        if (!tx_ready) begin
`ifdef FRAME_CHKSUM_EN
          if (r_chk_phase)          w_rd_done = 1'b1;
          else if (r_idx == r_last) w_next    = S_RD_CHK;
`else
          if (r_idx == r_last)      w_rd_done = 1'b1;
`endif
          else begin
            w_ptr_inc = 1'b1;
            w_next    = S_RD_FETCH;
          end
        end
      default: w_next = S_IDLE;
    endcase
    if (w_to_hit) w_err = 1'b1;
    if (w_err || w_wr_done || w_rd_done) w_next = S_IDLE;
  end

  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      r_pre     <= '0;
      r_wr      <= 1'b0;
      r_len_h   <= '0;
      r_last    <= '0;
      r_idx     <= '0;
      r_to      <= '0;
      r_tx_data <= '0;
      r_tx_flag <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tx_flag <= w_tx_flag;
      r_wr_done <= w_wr_done;
      r_rd_done <= w_rd_done;
      r_err     <= w_err;
      if (r_state != S_IDLE)
        r_pre <= '0;
      else if (rx_flag)
        r_pre <= (rx_data != PRE_BYTE) ? 4'd0 :
                 (r_pre == PRE_CNT[3:0]) ? r_pre : r_pre + 4'd1;
      if (rx_flag && r_state == S_CMD)   r_wr    <= (rx_data == CMD_WR);
      if (rx_flag && r_state == S_LEN_H) r_len_h <= rx_data;
      if (rx_flag && r_state == S_LEN_L) r_last  <= w_len - 16'd1;
      if (w_ptr_clr)      r_idx <= '0;
      else if (w_ptr_inc) r_idx <= r_idx + 16'd1;
      r_to <= (w_to_run && !rx_flag) ? r_to + 20'd1 : 20'd0;
      if (w_fetch) r_tx_data <= r_mem[r_idx[ADDR_W-1:0]];
`ifdef FRAME_CHKSUM_EN
      if (r_state == S_RD_CHK) r_tx_data <= r_sum;
`endif
    end

`ifdef FRAME_CHKSUM_EN
  // Running sum over CMD, LEN_H, LEN_L and the payload in either direction
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      r_sum       <= '0;
      r_chk_phase <= 1'b0;
    end else begin
      if (rx_flag && r_state == S_CMD)                         r_sum <= rx_data;
      else if (rx_flag && r_state inside {S_LEN_H, S_LEN_L})   r_sum <= r_sum + rx_data;
      else if (w_we)                                           r_sum <= r_sum + rx_data;
      else if (w_tx_flag && !r_chk_phase)                      r_sum <= r_sum + r_tx_data;
      if (w_ptr_clr)               r_chk_phase <= 1'b0;
      else if (r_state == S_RD_CHK) r_chk_phase <= 1'b1;
    end
`endif

  // Buffer is intentionally not reset
  always_ff @(posedge sclk)
    if (w_we) r_mem[r_idx[ADDR_W-1:0]] <= rx_data;

  assign tx_data  = r_tx_data;
  assign tx_flag  = r_tx_flag;
  assign busy     = (r_state != S_IDLE);
  assign wr_done  = r_wr_done;
  assign rd_done  = r_rd_done;
  assign err_flag = r_err;
endmodule

// File: tb/tb_uart_frame_ctrl_p.sv
// Bench for uart_frame_ctrl_p: byte-level frame model predicts the ordered stream of
// tx bytes and done/error pulses; a monitor matches every DUT pulse against it.
module tb_uart_frame_ctrl_p;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 256;
  localparam int PRE_CNT = 7;
  localparam int RX_TO   = 1000;
`ifdef FRAME_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       sclk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_flag = 1'b0, tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_flag, busy, wr_done, rd_done, err_flag;
  int         total = 0, bad = 0;
  int         tx_low = 100;

  always #5 sclk = ~sclk;

  uart_frame_ctrl_p #(.ADDR_W(ADDR_W), .PRE_CNT(PRE_CNT), .RX_TO(RX_TO)) dut (
    .sclk(sclk), .rst_n(rst_n), .rx_data(rx_data), .rx_flag(rx_flag), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_flag(tx_flag), .busy(busy), .wr_done(wr_done),
    .rd_done(rd_done), .err_flag(err_flag));

  typedef enum logic [1:0] {EV_TX, EV_WR, EV_RD, EV_ERR} ev_kind_t;
  typedef struct packed { ev_kind_t k; logic [7:0] d; } ev_t;
  typedef logic [7:0] bq_t [$];

  ev_t        exp_q [$];
  logic [7:0] tx_log [$];
  int         n_wr = 0, n_err = 0;

  // ---------------- frame model ----------------
  logic [7:0] m_mem [DEPTH];
  int         m_pre = 0;
  bit         m_in  = 1'b0;
  logic [7:0] m_hdr [$];   // bytes after SOF1: SOF2, CMD, LEN_H, LEN_L, payload, [chk]

  function automatic void push_ev(ev_kind_t k, logic [7:0] d);
    ev_t e;
    e.k = k; e.d = d;
    exp_q.push_back(e);
  endfunction

  function automatic void m_abort();
    push_ev(EV_ERR, 8'h00);
    m_in = 1'b0;
  endfunction

  function automatic void model_gap(int idle);
    if (m_in && idle >= RX_TO) m_abort();
  endfunction

  function automatic void model_byte(logic [7:0] b);
    int len, n;
    logic [7:0] s;
    if (!m_in) begin
      if (b == 8'h55)                      m_pre = (m_pre < PRE_CNT) ? m_pre + 1 : PRE_CNT;
      else if (b == 8'hD5 && m_pre == PRE_CNT) begin m_in = 1'b1; m_pre = 0; m_hdr.delete(); end
      else                                 m_pre = 0;
      return;
    end
    m_hdr.push_back(b);
    n = m_hdr.size();
    if (n == 1 && b != 8'hFA) m_abort();
    else if (n == 2 && b != 8'hAA && b != 8'h55) m_abort();
    else if (n >= 4) begin
      len = int'({m_hdr[2], m_hdr[3]});
      if (n == 4) begin
        if (len == 0 || len > DEPTH) m_abort();
        else if (m_hdr[1] == 8'h55) begin
          s = m_hdr[1] + m_hdr[2] + m_hdr[3];
          for (int i = 0; i < len; i++) begin push_ev(EV_TX, m_mem[i]); s += m_mem[i]; end
          if (CHK) push_ev(EV_TX, s);
          push_ev(EV_RD, 8'h00);
          m_in = 1'b0;
        end
      end else if (n <= 4 + len) begin
        m_mem[n-5] = b;
        if (n == 4 + len && !CHK) begin push_ev(EV_WR, 8'h00); m_in = 1'b0; end
      end else begin
        s = 8'h00;
        for (int i = 1; i < n - 1; i++) s += m_hdr[i];
        if (s == b) push_ev(EV_WR, 8'h00);
        else        push_ev(EV_ERR, 8'h00);
        m_in = 1'b0;
      end
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic got(input ev_kind_t k, input logic [7:0] d, input string name);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected pulse (data %02h), want none", name, d);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || (k == EV_TX && e.d != d)) begin
        bad++;
        $display("FAIL %s: got kind %0d data %02h want kind %0d data %02h",
                 name, int'(k), d, int'(e.k), e.d);
      end
    end
  endtask

  always @(negedge sclk) if (rst_n) begin
    if (tx_flag)  begin tx_log.push_back(tx_data); got(EV_TX, tx_data, "tx_flag"); end
    if (wr_done)  begin n_wr++;  got(EV_WR,  8'h00, "wr_done");  end
    if (rd_done)  got(EV_RD, 8'h00, "rd_done");
    if (err_flag) begin n_err++; got(EV_ERR, 8'h00, "err_flag"); end
  end

  // Transmitter stand-in: drops ready for tx_low cycles after each strobe
  initial forever begin
    @(negedge sclk);
    if (tx_flag) begin
      tx_ready = 1'b0;
      repeat (tx_low) @(negedge sclk);
      tx_ready = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input int idle);
    model_gap(idle);
    repeat (idle) @(negedge sclk);
    model_byte(b);
    rx_data = b; rx_flag = 1'b1;
    @(negedge sclk);
    rx_flag = 1'b0;
  endtask

  task automatic send_q(input bq_t q, input int idle);
    foreach (q[i]) send_byte(q[i], idle);
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) send_byte(8'h55, 1);
  endtask

  task automatic idle_for(input int n);
    model_gap(n);
    repeat (n) @(negedge sclk);
  endtask

  // Write frame; gap0 is the idle time before the first payload byte
  task automatic send_wr(input logic [15:0] len, input bq_t pl, input int gap0);
    logic [7:0] s;
    s = 8'hAA + len[15:8] + len[7:0];
    send_pre(PRE_CNT);
    send_q('{8'hD5, 8'hFA, 8'hAA, len[15:8], len[7:0]}, 1);
    foreach (pl[i]) begin send_byte(pl[i], (i == 0) ? gap0 : 1); s += pl[i]; end
    if (CHK) send_byte(s, 1);
  endtask

  task automatic send_rd(input logic [15:0] len);
    send_pre(PRE_CNT);
    send_q('{8'hD5, 8'hFA, 8'h55, len[15:8], len[7:0]}, 1);
  endtask

  task automatic drain(input string name, input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin @(negedge sclk); t++; end
    repeat (4) @(negedge sclk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected pulses never seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bq_t        pl;
    logic [7:0] exp4 [4];
    int         e0;
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (3) @(negedge sclk);
    chk("reset_outputs", {19'd0, busy, tx_flag, wr_done, rd_done, err_flag, tx_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge sclk);

    // Basic 4-byte write then read back with slow transmitter
    send_wr(16'd4, '{8'h11, 8'h22, 8'h33, 8'h44}, 1);
    drain("wr4", 200);
    chk("wr4_done_count", n_wr, 1);
    chk("wr4_no_err", n_err, 0);
    chk("wr4_idle_busy", {31'd0, busy}, 0);

    tx_log.delete();
    send_rd(16'd4);
    @(negedge sclk);
    chk("rd4_busy", {31'd0, busy}, 1);
    drain("rd4", 1500);
    chk("rd4_tx_count", tx_log.size(), 4 + int'(CHK));
    for (int i = 0; i < 4; i++) chk("rd4_tx_byte", tx_log[i], exp4[i]);

    // Preamble boundaries
    e0 = n_err;
    send_pre(6); send_byte(8'hD5, 1);
    drain("pre6", 20);
    chk("pre6_idle", {31'd0, busy}, 0);
    chk("pre6_no_err", n_err, e0);
    send_pre(9); send_q('{8'hD5, 8'hFA}, 1);
    repeat (2) @(negedge sclk);
    chk("pre9_in_cmd_busy", {31'd0, busy}, 1);
    send_byte(8'h00, 1);
    drain("pre9_bad_cmd", 20);
    send_pre(7); send_q('{8'hD5, 8'h00}, 1);
    drain("bad_sof2", 20);
    chk("bad_sof2_err", n_err, e0 + 2);
    chk("bad_sof2_idle", {31'd0, busy}, 0);

    // Length limits
    send_pre(7); send_q('{8'hD5, 8'hFA, 8'hAA, 8'h01, 8'h01, 8'h99, 8'h98}, 1);
    drain("len_257", 40);
    tx_low = 3;
    send_rd(16'd4);
    drain("rd_after_len257", 200);
    pl.delete();
    for (int i = 0; i < DEPTH; i++) pl.push_back(8'((i * 7 + 3) & 255));
    send_wr(16'h0100, pl, 1);
    drain("wr256", 200);
    send_rd(16'h0100);
    drain("rd256", 5000);

    // Receive timeout boundaries
    send_pre(7); send_q('{8'hD5, 8'hFA, 8'hAA, 8'h00, 8'h04}, 1);
    idle_for(RX_TO);
    drain("timeout_hdr", 20);
    chk("timeout_idle", {31'd0, busy}, 0);
    send_wr(16'd4, '{8'h11, 8'h22, 8'h33, 8'h44}, RX_TO - 1);
    drain("timeout_edge_ok", 40);
    send_pre(7); send_q('{8'hD5, 8'hFA, 8'hAA, 8'h00, 8'h04, 8'hA1, 8'hA2}, 1);
    idle_for(RX_TO + 5);
    drain("timeout_payload", 20);
    send_rd(16'd4);
    drain("rd_partial", 200);

`ifdef FRAME_CHKSUM_EN
    send_pre(7); send_q('{8'hD5, 8'hFA, 8'hAA, 8'h00, 8'h02, 8'h01, 8'h02, 8'hAF}, 1);
    drain("chk_good", 40);
    send_pre(7); send_q('{8'hD5, 8'hFA, 8'hAA, 8'h00, 8'h02, 8'h01, 8'h02, 8'h00}, 1);
    drain("chk_bad", 40);
    send_rd(16'd2);
    drain("chk_rd", 200);
`endif

    // Asynchronous reset mid-frame: no pulses, immediate idle
    send_pre(7); send_q('{8'hD5, 8'hFA, 8'hAA, 8'h00, 8'h04, 8'h5A}, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {19'd0, busy, tx_flag, wr_done, rd_done, err_flag, tx_data}, 32'd0);
    m_in = 1'b0; m_pre = 0;
    @(negedge sclk); rst_n = 1'b1;
    repeat (RX_TO + 10) @(negedge sclk);
    drain("after_reset_quiet", 10);
    chk("after_reset_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
